lcd_char_driver: RTL and testbench
==================================

LCD_CHAR_DRIVER -- requirements
Module: lcd_char_driver

Interface
REQ-001 Parameter TICK_DIV, default 50000, clk cycles per LCD step tick (1 ms at 50 MHz); legal minimum 4.
REQ-002 Parameter POWER_WAIT, default 20, step ticks idle after reset before first command.
REQ-003 Parameter CLEAR_WAIT, default 2, extra step ticks idle after the clear-display command.
REQ-004 clk  in  1  system clock; the only clock; all logic on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-low.
REQ-006 char_in  in  8  ASCII byte from the display-mode stage for the current index; valid 1 clk after index changes.
REQ-007 index  out  5  character slot requested from the mode stage: 0-15 line 1, 16-31 line 2.
REQ-008 lcd_rs  out  1  HD44780 register select: 0 command, 1 data.
REQ-009 lcd_rw  out  1  HD44780 read/write, held 0 (write only).
REQ-010 lcd_e  out  1  HD44780 enable strobe.
REQ-011 lcd_data  out  8  HD44780 8-bit data bus.
REQ-012 frame_done  out  1  one-clk pulse when slot 31 has been written.

Function
REQ-013 Free-running counter 0..TICK_DIV-1; step tick = 1-clk pulse when counter wraps to 0; all state and phase changes occur only on step ticks.
REQ-014 Every LCD write is 3 ticks: phase SETUP (rs, data driven, e=0), phase STROBE (e=1), phase HOLD (e=0); rs/data stable across all three phases.
REQ-015 States: POWER_UP -> INIT -> L1_ADDR -> L1_CHAR -> L2_ADDR -> L2_CHAR -> L1_ADDR (loops forever).
REQ-016 POWER_UP: lcd_e=0; counts POWER_WAIT ticks, then INIT.
REQ-017 INIT: writes commands 0x38, 0x0C, 0x06, 0x01 in order (rs=0); after 0x01 HOLD, idles CLEAR_WAIT ticks, then L1_ADDR.
REQ-018 L1_ADDR writes command 0x80; L2_ADDR writes command 0xC0.
REQ-019 L1_CHAR writes 16 data bytes (rs=1) for index 0..15; L2_CHAR for index 16..31.
REQ-020 index set to the slot number at the tick entering SETUP of that slot's write; it holds through HOLD.
REQ-021 lcd_data for a char write is char_in sampled at the tick entering STROBE (>=TICK_DIV clk after index change, satisfying source latency); during SETUP lcd_data shows char_in live.
REQ-022 After HOLD of slot 15 -> L2_ADDR; after HOLD of slot 31 -> frame_done pulses on that tick, index wraps to 0, -> L1_ADDR.
REQ-023 In command states index holds its last value; index never exceeds 31.
REQ-024 Changes of char_in outside the sampling tick do not alter an in-progress write.

Reset
REQ-025 rst=0 at a clk edge: state POWER_UP, tick counter 0, phase SETUP, wait counter 0, index 0, lcd_rs 0, lcd_rw 0, lcd_e 0, lcd_data 0x00, frame_done 0.
REQ-026 Reset mid-write (including with lcd_e=1) forces lcd_e=0 on the same edge and restarts the full power-up and init sequence.

Structure
REQ-027 Shared package holds the state enumeration and command constants (CMD_FUNC_SET 0x38, CMD_DISP_ON 0x0C, CMD_ENTRY 0x06, CMD_CLEAR 0x01, CMD_LINE1 0x80, CMD_LINE2 0xC0).
REQ-028 One sub-module, lcd_tick_gen, produces the step tick from TICK_DIV; everything else lives in lcd_char_driver.

Verification (TICK_DIV=4, POWER_WAIT=2, CLEAR_WAIT=2, LCD bus model logs bytes on lcd_e falling edge)
REQ-029 Release reset -> lcd_e stays 0 for 2 ticks, then logged commands 0x38, 0x0C, 0x06, 0x01; ≥2 idle ticks after 0x01 before 0x80.
REQ-030 Mode-stage model returns 0x41+index with 1-clk latency -> log after init is 0x80, 0x41..0x50 (rs=1), 0xC0, 0x51..0x60, frame_done pulses once.
REQ-031 Run 3 frames -> frame_done exactly 3 single-clk pulses; each frame starts with 0x80; index sequence 0..31 with no gaps or repeats.
REQ-032 char_in toggles randomly except at sampling ticks -> every logged byte equals model value for its index.
REQ-033 Assert rst=0 for 1 clk while lcd_e=1 during slot 20 -> lcd_e=0 next edge, index=0, sequence restarts at power-up wait then 0x38.
REQ-034 Throughout all runs -> lcd_rw always 0; rs/data never change while lcd_e=1.

Source files
------------

// File: rtl/lcd_char_driver_pkg.sv
// rtl/lcd_char_driver_pkg.sv - shared states, phases and HD44780 command constants
package lcd_char_driver_pkg;

    typedef enum logic [2:0] {
        ST_POWER_UP,
        ST_INIT,
        ST_L1_ADDR,
        ST_L1_CHAR,
        ST_L2_ADDR,
        ST_L2_CHAR
    } lcd_state_e;

    // PH_WAIT is the idle gap after the clear command, outside any write
    typedef enum logic [1:0] {
        PH_SETUP,
        PH_STROBE,
        PH_HOLD,
        PH_WAIT
    } lcd_phase_e;

    localparam logic [7:0] CMD_FUNC_SET = 8'h38;
    localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
    localparam logic [7:0] CMD_ENTRY    = 8'h06;
    localparam logic [7:0] CMD_CLEAR    = 8'h01;
    localparam logic [7:0] CMD_LINE1    = 8'h80;
    localparam logic [7:0] CMD_LINE2    = 8'hC0;

    localparam logic [1:0] INIT_LAST     = 2'd3;
    localparam logic [4:0] SLOT_L1_FIRST = 5'd0;
    localparam logic [4:0] SLOT_L1_LAST  = 5'd15;
    localparam logic [4:0] SLOT_L2_FIRST = 5'd16;
    localparam logic [4:0] SLOT_L2_LAST  = 5'd31;

    function automatic logic [7:0] init_cmd(input logic [1:0] step);
        logic [7:0] cmd;
        case (step)
            2'd0:    cmd = CMD_FUNC_SET;
            2'd1:    cmd = CMD_DISP_ON;
            2'd2:    cmd = CMD_ENTRY;
            default: cmd = CMD_CLEAR;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/lcd_char_driver_if.sv
// rtl/lcd_char_driver_if.sv - mode-stage request/response plus HD44780 bus
interface lcd_char_driver_if;
    logic [7:0] char_in;
    logic [4:0] index;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_e;
    logic [7:0] lcd_data;
    logic       frame_done;

    modport master (
        input  char_in,
        output index,
        output lcd_rs,
        output lcd_rw,
        output lcd_e,
        output lcd_data,
        output frame_done
    );

    modport slave (
        output char_in,
        input  index,
        input  lcd_rs,
        input  lcd_rw,
        input  lcd_e,
        input  lcd_data,
        input  frame_done
    );
endinterface

// File: rtl/lcd_tick_gen.sv
// rtl/lcd_tick_gen.sv - free-running divider producing the LCD step tick
module lcd_tick_gen #(
    parameter int unsigned TICK_DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    output logic tick_o
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The step happens on the edge where the counter wraps back to 0
    assign tick_o = (cnt_q == CNT_LAST);

endmodule

// File: rtl/lcd_char_driver.sv
// rtl/lcd_char_driver.sv - HD44780 8-bit init and 2x16 refresh sequencer
module lcd_char_driver
    import lcd_char_driver_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 50000,
    parameter int unsigned POWER_WAIT = 20,
    parameter int unsigned CLEAR_WAIT = 2
) (
    input  logic                clk,
    input  logic                rst,
    lcd_char_driver_if.master   bus
);

    logic tick;

    lcd_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .tick_o (tick)
    );

    lcd_state_e  state_q, state_d;
    lcd_phase_e  phase_q, phase_d;
    logic [15:0] wait_q, wait_d;
    logic [1:0]  step_q, step_d;
    logic [4:0]  index_q, index_d;
    logic        rs_q, rs_d;
    logic        e_q, e_d;
    logic [7:0]  data_q, data_d;
    logic        frame_done_q, frame_done_d;
    logic        char_state;

    assign char_state = (state_q == ST_L1_CHAR) || (state_q == ST_L2_CHAR);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_POWER_UP;
            phase_q      <= PH_SETUP;
            wait_q       <= '0;
            step_q       <= '0;
            index_q      <= '0;
            rs_q         <= 1'b0;
            e_q          <= 1'b0;
            data_q       <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            wait_q       <= wait_d;
            step_q       <= step_d;
            index_q      <= index_d;
            rs_q         <= rs_d;
            e_q          <= e_d;
            data_q       <= data_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        wait_d       = wait_q;
        step_d       = step_q;
        index_d      = index_q;
        rs_d         = rs_q;
        e_d          = e_q;
        data_d       = data_q;
        frame_done_d = 1'b0;

        if (tick) begin
            if (state_q == ST_POWER_UP) begin
                if (32'(wait_q) + 32'd1 >= POWER_WAIT) begin
                    state_d = ST_INIT;
                    phase_d = PH_SETUP;
                    wait_d  = '0;
                    step_d  = '0;
                    rs_d    = 1'b0;
                    data_d  = init_cmd(2'd0);
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end else begin
                case (phase_q)
                    PH_SETUP: begin
                        phase_d = PH_STROBE;
                        e_d     = 1'b1;
                        // Latching here keeps the strobed byte immune to later char_in churn
                        if (char_state) begin
                            data_d = bus.char_in;
                        end
                    end
                    PH_STROBE: begin
                        phase_d = PH_HOLD;
                        e_d     = 1'b0;
                    end
                    PH_HOLD: begin
                        phase_d = PH_SETUP;
                        case (state_q)
                            ST_INIT: begin
                                if (step_q != INIT_LAST) begin
                                    step_d = step_q + 2'd1;
                                    data_d = init_cmd(step_q + 2'd1);
                                end else if (CLEAR_WAIT == 0) begin
                                    state_d = ST_L1_ADDR;
                                    data_d  = CMD_LINE1;
                                end else begin
                                    phase_d = PH_WAIT;
                                    wait_d  = '0;
                                end
                            end
                            ST_L1_ADDR: begin
                                state_d = ST_L1_CHAR;
                                rs_d    = 1'b1;
                                index_d = SLOT_L1_FIRST;
                            end
                            ST_L1_CHAR: begin
                                if (index_q == SLOT_L1_LAST) begin
                                    state_d = ST_L2_ADDR;
                                    rs_d    = 1'b0;
                                    data_d  = CMD_LINE2;
                                end else begin
                                    index_d = index_q + 5'd1;
                                end
                            end
                            ST_L2_ADDR: begin
                                state_d = ST_L2_CHAR;
                                rs_d    = 1'b1;
                                index_d = SLOT_L2_FIRST;
                            end
                            ST_L2_CHAR: begin
                                if (index_q == SLOT_L2_LAST) begin
                                    state_d      = ST_L1_ADDR;
                                    rs_d         = 1'b0;
                                    data_d       = CMD_LINE1;
                                    index_d      = SLOT_L1_FIRST;
                                    frame_done_d = 1'b1;
                                end else begin
                                    index_d = index_q + 5'd1;
                                end
                            end
                            default: begin
                                state_d = ST_POWER_UP;
                                wait_d  = '0;
                            end
                        endcase
                    end
                    default: begin
                        if (32'(wait_q) + 32'd1 >= CLEAR_WAIT) begin
                            state_d = ST_L1_ADDR;
                            phase_d = PH_SETUP;
                            wait_d  = '0;
                            rs_d    = 1'b0;
                            data_d  = CMD_LINE1;
                        end else begin
                            wait_d = wait_q + 16'd1;
                        end
                    end
                endcase
            end
        end
    end

    assign bus.index      = index_q;
    assign bus.lcd_rs     = rs_q;
    assign bus.lcd_rw     = 1'b0;
    assign bus.lcd_e      = e_q;
    assign bus.lcd_data   = (char_state && (phase_q == PH_SETUP)) ? bus.char_in : data_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_lcd_char_driver.sv
// tb/tb_lcd_char_driver.sv - scoreboard bench for lcd_char_driver
module tb_lcd_char_driver;

    localparam int unsigned TICK_DIV   = 4;
    localparam int unsigned POWER_WAIT = 2;
    localparam int unsigned CLEAR_WAIT = 2;

    logic clk = 1'b0;
    logic rst;

    lcd_char_driver_if bus ();

    lcd_char_driver #(
        .TICK_DIV   (TICK_DIV),
        .POWER_WAIT (POWER_WAIT),
        .CLEAR_WAIT (CLEAR_WAIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [8:0] exp_q[$];
    int         cnt;
    int         tick_num;
    logic       rst_edge;
    logic       prev_e;
    logic       prev_fd;
    logic       cap_rs;
    logic [7:0] cap_data;
    logic       first_rise_seen;
    logic [8:0] last_fall_byte;
    int         last_fall_tick;
    int         exp_slot;
    int         n_chars;
    int         frames;
    logic       rand_en;
    logic       hit20;
    logic       seen_line1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_init();
        exp_q.push_back(9'h038);
        exp_q.push_back(9'h00C);
        exp_q.push_back(9'h006);
        exp_q.push_back(9'h001);
    endtask

    task automatic push_frame();
        exp_q.push_back(9'h080);
        for (int i = 0; i < 16; i++) exp_q.push_back(9'h100 | 9'(8'h41 + i));
        exp_q.push_back(9'h0C0);
        for (int i = 16; i < 32; i++) exp_q.push_back(9'h100 | 9'(8'h41 + i));
    endtask

    // One clock: track the tick phase at the edge, then check and drive at the falling edge
    task automatic cyc();
        logic [8:0] got;
        logic [8:0] exp;
        @(posedge clk);
        rst_edge = !rst;
        if (!rst) begin
            cnt      = 0;
            tick_num = 0;
        end else if (cnt == int'(TICK_DIV) - 1) begin
            cnt = 0;
            tick_num++;
        end else begin
            cnt++;
        end
        @(negedge clk);
        chk("lcd_rw_low", 32'(bus.lcd_rw), 32'd0);
        if (!rst_edge) begin
            if (bus.lcd_e && !prev_e) begin
                cap_rs   = bus.lcd_rs;
                cap_data = bus.lcd_data;
                if (!first_rise_seen) begin
                    chk("powerup_idle", 32'(tick_num > int'(POWER_WAIT)), 32'd1);
                    first_rise_seen = 1'b1;
                end
                if (!bus.lcd_rs && bus.lcd_data == 8'h80 && last_fall_byte == 9'h001) begin
                    chk("clear_gap", 32'(tick_num - last_fall_tick >= int'(CLEAR_WAIT) + 2), 32'd1);
                end
                if (bus.lcd_rs) begin
                    chk("index_seq", 32'(bus.index), 32'(exp_slot));
                    exp_slot = (exp_slot + 1) % 32;
                    n_chars++;
                    if (bus.index == 5'd20 && frames >= 3) hit20 = 1'b1;
                end
            end else if (bus.lcd_e && prev_e) begin
                chk("rs_stable", 32'(bus.lcd_rs), 32'(cap_rs));
                chk("data_stable", 32'(bus.lcd_data), 32'(cap_data));
            end else if (!bus.lcd_e && prev_e) begin
                got = {bus.lcd_rs, bus.lcd_data};
                chk("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    exp = exp_q.pop_front();
                    chk("lcd_write", 32'(got), 32'(exp));
                end
                last_fall_byte = got;
                last_fall_tick = tick_num;
                if (got == 9'h080) seen_line1 = 1'b1;
            end
            if (bus.frame_done) begin
                chk("fd_single", 32'(prev_fd), 32'd0);
                chk("fd_after_31", 32'(last_fall_byte), 32'h160);
                chk("fd_sb_empty", 32'(exp_q.size()), 32'd0);
                frames++;
                push_frame();
            end
        end
        prev_e  = bus.lcd_e;
        prev_fd = bus.frame_done;
        if (rand_en && frames >= 1 && cnt != int'(TICK_DIV) - 1) begin
            bus.char_in = 8'($urandom_range(0, 255));
        end else begin
            bus.char_in = 8'h41 + {3'b000, bus.index};
        end
    endtask

    initial begin
        rst             = 1'b0;
        bus.char_in     = 8'h00;
        cnt             = 0;
        tick_num        = 0;
        prev_e          = 1'b0;
        prev_fd         = 1'b0;
        cap_rs          = 1'b0;
        cap_data        = 8'h00;
        first_rise_seen = 1'b0;
        last_fall_byte  = 9'h000;
        last_fall_tick  = 0;
        exp_slot        = 0;
        n_chars         = 0;
        frames          = 0;
        rand_en         = 1'b1;
        hit20           = 1'b0;
        seen_line1      = 1'b0;

        repeat (3) cyc();
        chk("rst_lcd_e", 32'(bus.lcd_e), 32'd0);
        chk("rst_lcd_rs", 32'(bus.lcd_rs), 32'd0);
        chk("rst_lcd_data", 32'(bus.lcd_data), 32'h00);
        chk("rst_index", 32'(bus.index), 32'd0);
        chk("rst_frame_done", 32'(bus.frame_done), 32'd0);

        push_init();
        push_frame();
        rst = 1'b1;
        for (int i = 0; i < 4000 && frames < 3; i++) cyc();
        chk("frames_run", 32'(frames), 32'd3);
        chk("chars_written", 32'(n_chars), 32'd96);

        for (int i = 0; i < 1000 && !hit20; i++) cyc();
        chk("slot20_reached", 32'(hit20), 32'd1);
        chk("slot20_strobe", 32'(bus.lcd_e), 32'd1);

        rst = 1'b0;
        cyc();
        chk("midrst_lcd_e", 32'(bus.lcd_e), 32'd0);
        chk("midrst_index", 32'(bus.index), 32'd0);
        chk("midrst_lcd_rs", 32'(bus.lcd_rs), 32'd0);
        chk("midrst_lcd_data", 32'(bus.lcd_data), 32'h00);
        chk("midrst_frame_done", 32'(bus.frame_done), 32'd0);

        exp_q.delete();
        push_init();
        push_frame();
        exp_slot        = 0;
        first_rise_seen = 1'b0;
        seen_line1      = 1'b0;
        last_fall_byte  = 9'h000;
        rst             = 1'b1;
        for (int i = 0; i < 600 && !seen_line1; i++) cyc();
        chk("restart_line1", 32'(seen_line1), 32'd1);
        chk("restart_sb_left", 32'(exp_q.size()), 32'd33);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
